// File: rtl/polar_encoder_pkg.sv
// Shared constants, FSM state type and elaboration-time helpers for the
// polar encoder. Optional LLR output is enabled with POLAR_ENC_LLR_EN.
package polar_encoder_pkg;

    // LLR fixed-point format: two's complement, 1 sign, 7 integer, 12 fraction
    localparam int LLR_W    = 20;
    localparam int LLR_FRAC = 12;

    localparam logic [LLR_W-1:0] LLR_POS_ONE = 20'h01000;
    localparam logic [LLR_W-1:0] LLR_NEG_ONE = 20'hFF000;

    // Widest frozen mask the helper functions can scan
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ENC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Number of non-frozen (mask bit = 0) positions among the low n bits
    function automatic int count_free(input logic [MAX_N-1:0] mask, input int n);
        int c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !mask[i]) c++;
        end
        return c;
    endfunction

    // Index of the k-th non-frozen position (ascending, k counts from 0)
    function automatic int free_index(input logic [MAX_N-1:0] mask, input int n,
                                      input int k);
        int c;
        int idx;
        c   = 0;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !mask[i]) begin
                if (c == k) idx = i;
                c++;
            end
        end
        return idx;
    endfunction

    // BPSK mapping: code bit 0 -> +1.0, code bit 1 -> -1.0
    function automatic logic [LLR_W-1:0] bpsk_llr(input logic x);
        return x ? LLR_NEG_ONE : LLR_POS_ONE;
    endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// Handshake bundle of the polar encoder. The master side (stimulus/consumer)
// drives in_valid/in_bit/out_ready; the slave side (encoder) drives the rest.
// out_llr exists only when POLAR_ENC_LLR_EN is defined.
//
// Handshake rule (both channels): a transfer happens on the rising clock edge
// where valid & ready are both 1; a producer holding valid keeps its data
// stable until that edge, and valid never drops without a transfer.
import polar_encoder_pkg::*;

interface polar_encoder_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_cw;
`ifdef POLAR_ENC_LLR_EN
    logic [LLR_W*N-1:0] out_llr;
`endif

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_cw
`ifdef POLAR_ENC_LLR_EN
        ,
        input  out_llr
`endif
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_cw
`ifdef POLAR_ENC_LLR_EN
        ,
        output out_llr
`endif
    );
endinterface

// File: rtl/polar_enc_stage.sv
// One butterfly stage of the polar transform, selected at run time by s_i.
// For every j whose bit s is 0: v'[j] = v[j] ^ v[j + 2^s]; other bits pass.
module polar_enc_stage #(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic [N-1:0]  v_i,
    input  logic [SW-1:0] s_i,
    output logic [N-1:0]  v_o
);
    // Partner selection is resolved per (bit, stage) at elaboration so no
    // out-of-range partner index is ever formed.
    for (genvar j = 0; j < N; j++) begin : g_bit
        logic [LOG2N-1:0] partner;
        for (genvar t = 0; t < LOG2N; t++) begin : g_stage
            if (((j >> t) & 1) == 0) begin : g_upper
                assign partner[t] = v_i[j + (1 << t)] & (s_i == SW'(t));
            end else begin : g_lower
                assign partner[t] = 1'b0;
            end
        end
        assign v_o[j] = v_i[j] ^ (|partner);
    end
endmodule

// File: rtl/polar_encoder.sv
// Serial-in, parallel-out polar encoder: x = u * F^{(x)n}, no bit reversal.
// Info bits fill the non-frozen positions of u one per handshake, the
// butterfly is applied one stage per cycle, and the codeword is held on a
// valid/ready output. Define POLAR_ENC_LLR_EN to add BPSK-mapped LLR output.
module polar_encoder
    import polar_encoder_pkg::*;
#(
    parameter int           N           = 8,
    parameter int           LOG2N       = 3,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic           clk,
    input  logic           rst_n,
    polar_encoder_if.slave bus,
    output state_t         dbg_state_o
);
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [CNT_W-1:0] LAST_INFO  = CNT_W'(K - 1);

    // Configuration sanity checks, raised at elaboration
    if (N > MAX_N || N < 2 || (1 << LOG2N) != N) begin : g_bad_n
        $error("polar_encoder: N must be a power of two in [2, %0d] equal to 2**LOG2N", MAX_N);
    end
    if (count_free(MAX_N'(FROZEN_MASK), N) != K) begin : g_bad_k
        $error("polar_encoder: FROZEN_MASK must leave exactly K non-frozen positions");
    end

    // Non-frozen index table, constant after elaboration
    logic [LOG2N-1:0] nf_idx [K];
    for (genvar g = 0; g < K; g++) begin : g_nf
        assign nf_idx[g] = LOG2N'(free_index(MAX_N'(FROZEN_MASK), N, g));
    end

    state_t           state_q;
    logic [CNT_W-1:0] info_cnt_q;
    logic [SW-1:0]    stage_q;
    logic [N-1:0]     v_q;
    logic [N-1:0]     v_d;
    logic             out_valid_q;
    logic [N-1:0]     out_cw_q;
`ifdef POLAR_ENC_LLR_EN
    logic [LLR_W*N-1:0] out_llr_q;
    logic [LLR_W*N-1:0] llr_d;
`endif

    // Single butterfly stage, reused for every ENC cycle
    polar_enc_stage #(
        .N    (N),
        .LOG2N(LOG2N),
        .SW   (SW)
    ) u_stage (
        .v_i(v_q),
        .s_i(stage_q),
        .v_o(v_d)
    );

`ifdef POLAR_ENC_LLR_EN
    // BPSK map of the final-stage result, captured alongside out_cw
    always_comb begin
        llr_d = '0;
        for (int j = 0; j < N; j++) begin
            llr_d[LLR_W*j +: LLR_W] = bpsk_llr(v_d[j]);
        end
    end
`endif

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            info_cnt_q  <= '0;
            stage_q     <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_cw_q    <= '0;
`ifdef POLAR_ENC_LLR_EN
            out_llr_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        v_q[nf_idx[info_cnt_q]] <= bus.in_bit;
                        if (info_cnt_q == LAST_INFO) begin
                            info_cnt_q <= '0;
                            stage_q    <= '0;
                            state_q    <= ST_ENC;
                        end else begin
                            info_cnt_q <= info_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ENC: begin
                    v_q <= v_d;
                    if (stage_q == LAST_STAGE) begin
                        stage_q     <= '0;
                        out_valid_q <= 1'b1;
                        out_cw_q    <= v_d;
`ifdef POLAR_ENC_LLR_EN
                        out_llr_q   <= llr_d;
`endif
                        state_q     <= ST_OUT;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        v_q         <= '0;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_cw    = out_cw_q;
`ifdef POLAR_ENC_LLR_EN
    assign bus.out_llr   = out_llr_q;
`endif
    assign dbg_state_o   = state_q;

endmodule
